memc_engine: RTL and testbench

MEMC_ENGINE -- requirements
Module: memc_engine

---
 rtl/memc_engine.sv | 111 +++++++++++
 tb/tb_memc_engine.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memc_engine.sv
// memc_engine: multi-cycle word copy engine (memcpy) that stalls the core.
// Ports: clk/rst, multi_cy+src/dst/len start request, mem_* data-memory bus, stall/busy/done/align_err status.
module memc_engine #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             multi_cy,
  input  logic [WIDTH-1:0] src_addr,
  input  logic [WIDTH-1:0] dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_re,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             align_err
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] src_q;
  logic [WIDTH-1:0] dst_q;
  logic [LEN_W-1:0] cnt_q;
  logic             align_q;

  logic misal;
  assign misal = (src_addr[1:0] != 2'b00) ||
                 (dst_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      align_q <= 1'b0;
    end else begin
      align_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (multi_cy) begin
            if (misal) begin
              align_q <= 1'b1;
            end else begin
              src_q   <= src_addr;
              dst_q   <= dst_addr;
              cnt_q   <= len;
              state_q <= (len == '0) ? DONE : READ;
            end
          end
        end
        READ: state_q <= WRITE;
        WRITE: begin
          src_q   <= src_q + WIDTH'(4);
          dst_q   <= dst_q + WIDTH'(4);
          cnt_q   <= cnt_q - LEN_W'(1);
          // last word when the count is about to hit zero
          state_q <= (cnt_q == LEN_W'(1)) ? DONE : READ;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    stall     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: stall = multi_cy;
      READ: begin
        mem_addr = src_q;
        mem_re   = 1'b1;
        stall    = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        // read data returns this cycle and goes straight back out
        mem_addr  = dst_q;
        mem_we    = 1'b1;
        mem_wdata = mem_rdata;
        stall     = 1'b1;
        busy      = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign align_err = align_q;

endmodule

// File: tb/tb_memc_engine.sv
// tb_memc_engine: randomized self-checking bench for memc_engine.
// Memory model + high-level copy model (array copy, access trace, latency 2*len+1).
module tb_memc_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        multi_cy;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        stall;
  logic        busy;
  logic        done;
  logic        align_err;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  acc_t trace[$];
  acc_t expq[$];

  logic [31:0] mem  [logic [29:0]];
  logic [31:0] refm [logic [29:0]];

  memc_engine #(.WIDTH(32), .LEN_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .multi_cy(multi_cy),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .len(len),
    .mem_rdata(mem_rdata),
    .mem_addr(mem_addr),
    .mem_re(mem_re),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .stall(stall),
    .busy(busy),
    .done(done),
    .align_err(align_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] rd_mem(logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return dflt(a);
  endfunction

  function automatic logic [31:0] rd_ref(logic [31:0] a);
    if (refm.exists(a[31:2])) return refm[a[31:2]];
    return dflt(a);
  endfunction

  always @(posedge clk) begin
    if (mem_re) begin
      mem_rdata <= rd_mem(mem_addr);
      trace.push_back('{1'b0, mem_addr, 32'h0});
    end
    if (mem_we) begin
      mem[mem_addr[31:2]] = mem_wdata;
      trace.push_back('{1'b1, mem_addr, mem_wdata});
    end
  end

  task automatic model_copy(input logic [31:0] s, input logic [31:0] d,
                            input int n);
    logic [31:0] a, b, v;
    for (int i = 0; i < n; i++) begin
      a = s + 32'(4 * i);
      b = d + 32'(4 * i);
      v = rd_ref(a);
      refm[b[31:2]] = v;
      expq.push_back('{1'b0, a, 32'h0});
      expq.push_back('{1'b1, b, v});
    end
  endtask

  task automatic do_copy(input logic [31:0] s, input logic [31:0] d,
                         input logic [15:0] n, input string nm);
    int k;
    int bad;
    bit got;
    trace.delete();
    expq.delete();
    @(negedge clk);
    multi_cy = 1'b1;
    src_addr = s;
    dst_addr = d;
    len = n;
    #1;
    checks++;
    if (stall !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s start: stall=%b busy=%b want 1 0", nm, stall, busy);
    end
    @(posedge clk);
    model_copy(s, d, int'(n));
    @(negedge clk);
    multi_cy = 1'b0;
    k = 1;
    got = 0;
    bad = 0;
    while (k <= 2 * int'(n) + 20) begin
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      if (busy !== 1'b1 || stall !== 1'b1 || align_err !== 1'b0) bad++;
      @(negedge clk);
      k++;
    end
    checks++;
    if (!got || k != 2 * int'(n) + 1) begin
      errs++;
      $display("FAIL %s done_latency: got=%0d cycle=%0d want cycle %0d",
               nm, got, k, 2 * int'(n) + 1);
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL %s busy_stall_profile: bad cycles=%0d want 0", nm, bad);
    end
    checks++;
    if (stall !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL %s done_cycle: stall=%b busy=%b want 0 1", nm, stall, busy);
    end
    @(negedge clk);
    checks++;
    if ({mem_re, mem_we, busy, done, stall, align_err} !== 6'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errs++;
      $display("FAIL %s idle_outputs: re=%b we=%b busy=%b done=%b addr=%h wd=%h want all 0",
               nm, mem_re, mem_we, busy, done, mem_addr, mem_wdata);
    end
    checks++;
    if (trace.size() != expq.size()) begin
      errs++;
      $display("FAIL %s trace_len: got %0d want %0d", nm, trace.size(), expq.size());
    end
    for (int i = 0; i < trace.size() && i < expq.size(); i++) begin
      checks++;
      if (trace[i].we !== expq[i].we || trace[i].addr !== expq[i].addr ||
          trace[i].data !== expq[i].data) begin
        errs++;
        $display("FAIL %s access[%0d]: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                 nm, i, trace[i].we, trace[i].addr, trace[i].data,
                 expq[i].we, expq[i].addr, expq[i].data);
      end
    end
    foreach (refm[w]) begin
      checks++;
      if (rd_mem({w, 2'b00}) !== refm[w]) begin
        errs++;
        $display("FAIL %s mem[%h]: got %h want %h", nm, {w, 2'b00},
                 rd_mem({w, 2'b00}), refm[w]);
      end
    end
    foreach (mem[w]) begin
      checks++;
      if (mem[w] !== rd_ref({w, 2'b00})) begin
        errs++;
        $display("FAIL %s stray_write[%h]: got %h want %h", nm, {w, 2'b00},
                 mem[w], rd_ref({w, 2'b00}));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    multi_cy = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len = '0;
    #12;
    checks++;
    if ({mem_re, mem_we, busy, done, stall, align_err} !== 6'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errs++;
      $display("FAIL reset_outputs: re=%b we=%b busy=%b done=%b stall=%b err=%b want 0",
               mem_re, mem_we, busy, done, stall, align_err);
    end
    multi_cy = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_stall_follows: stall=%b busy=%b want 1 0", stall, busy);
    end
    multi_cy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: stall=%b busy=%b want 0 0", stall, busy);
    end
  endtask

  task automatic test_basic();
    do_copy(32'h100, 32'h200, 16'd3, "basic");
  endtask

  task automatic test_len_zero();
    do_copy(32'h300, 32'h340, 16'd0, "len0");
  endtask

  task automatic test_wrap();
    do_copy(32'hFFFF_FFFC, 32'h500, 16'd2, "wrap");
  endtask

  task automatic test_random();
    logic [31:0] s, d;
    logic [15:0] n;
    for (int i = 0; i < 10; i++) begin
      s = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
      d = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
      n = 16'($urandom_range(0, 7));
      do_copy(s, d, n, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_align();
    logic [31:0] s, d;
    for (int i = 0; i < 4; i++) begin
      s = (i == 0) ? 32'h102 : 32'h2000 + 32'($urandom_range(0, 15)) * 4;
      d = 32'h2200 + 32'($urandom_range(0, 15)) * 4;
      if (i == 1) d[1:0] = 2'(1 + $urandom_range(0, 2));
      if (i >= 2) s[1:0] = 2'(1 + $urandom_range(0, 2));
      trace.delete();
      @(negedge clk);
      multi_cy = 1'b1;
      src_addr = s;
      dst_addr = d;
      len = 16'd3;
      @(negedge clk);
      multi_cy = 1'b0;
      checks++;
      if (align_err !== 1'b1 || busy !== 1'b0) begin
        errs++;
        $display("FAIL align%0d pulse: err=%b busy=%b want 1 0", i, align_err, busy);
      end
      @(negedge clk);
      checks++;
      if (align_err !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL align%0d after: err=%b busy=%b want 0 0", i, align_err, busy);
      end
      checks++;
      if (trace.size() != 0) begin
        errs++;
        $display("FAIL align%0d access: got %0d accesses want 0", i, trace.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    trace.delete();
    expq.delete();
    @(negedge clk);
    multi_cy = 1'b1;
    src_addr = 32'h3000;
    dst_addr = 32'h3100;
    len = 16'd4;
    @(negedge clk);
    multi_cy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_immediate: we=%b busy=%b stall=%b want 0", mem_we, busy, stall);
    end
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL rstmid_quiet: bad cycles=%0d want 0", bad);
    end
    model_copy(32'h3000, 32'h3100, 1);
    expq.push_back('{1'b0, 32'h3004, 32'h0});
    checks++;
    if (trace.size() != expq.size()) begin
      errs++;
      $display("FAIL rstmid_trace_len: got %0d want %0d", trace.size(), expq.size());
    end
    for (int i = 0; i < trace.size() && i < expq.size(); i++) begin
      checks++;
      if (trace[i].we !== expq[i].we || trace[i].addr !== expq[i].addr ||
          trace[i].data !== expq[i].data) begin
        errs++;
        $display("FAIL rstmid_access[%0d]: got we=%b a=%h want we=%b a=%h",
                 i, trace[i].we, trace[i].addr, expq[i].we, expq[i].addr);
      end
    end
    foreach (mem[w]) begin
      checks++;
      if (mem[w] !== rd_ref({w, 2'b00})) begin
        errs++;
        $display("FAIL rstmid_mem[%h]: got %h want %h", {w, 2'b00},
                 mem[w], rd_ref({w, 2'b00}));
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    bit got;
    trace.delete();
    expq.delete();
    @(negedge clk);
    multi_cy = 1'b1;
    src_addr = 32'h4000;
    dst_addr = 32'h4100;
    len = 16'd2;
    @(posedge clk);
    model_copy(32'h4000, 32'h4100, 2);
    k = 0;
    got = 0;
    while (k < 30) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got || k != 5) begin
      errs++;
      $display("FAIL hold_first_done: got=%0d cycle=%0d want cycle 5", got, k);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL hold_idle_gap: busy=%b stall=%b done=%b want 0 1 0", busy, stall, done);
    end
    @(posedge clk);
    model_copy(32'h4000, 32'h4100, 2);
    @(negedge clk);
    multi_cy = 1'b0;
    checks++;
    if (busy !== 1'b1 || mem_re !== 1'b1) begin
      errs++;
      $display("FAIL hold_relatch: busy=%b re=%b want 1 1", busy, mem_re);
    end
    k = 1;
    got = 0;
    while (k < 30) begin
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clk);
      k++;
    end
    checks++;
    if (!got || k != 5) begin
      errs++;
      $display("FAIL hold_second_done: got=%0d cycle=%0d want cycle 5", got, k);
    end
    @(negedge clk);
    checks++;
    if (trace.size() != expq.size()) begin
      errs++;
      $display("FAIL hold_trace_len: got %0d want %0d", trace.size(), expq.size());
    end
    for (int i = 0; i < trace.size() && i < expq.size(); i++) begin
      checks++;
      if (trace[i].we !== expq[i].we || trace[i].addr !== expq[i].addr ||
          trace[i].data !== expq[i].data) begin
        errs++;
        $display("FAIL hold_access[%0d]: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                 i, trace[i].we, trace[i].addr, trace[i].data,
                 expq[i].we, expq[i].addr, expq[i].data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_wrap();
    test_align();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
